// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   state_t        - loader FSM states
//   HDR_BYTES      - bytes in the little-endian word-count header
//   BYTES_PER_WORD - bytes per instruction word
//   CSUM_W         - width of the running checksum
package loader_pkg;

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_CSUM  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_W         = 8;

endpackage

// File: rtl/loader_byte_packer.sv
// loader_byte_packer: assembles 4 accepted bytes into a little-endian word.
//   clk, rst      - clock, synchronous active-low reset
//   clear         - drop any partial word (restart of a load)
//   byte_en       - a byte is accepted this cycle
//   byte_in       - the accepted byte
//   word          - {byte_in, stored bytes 2..0}; valid when word_done=1
//   word_done     - this cycle's byte completes a word
// The 4th byte is not stored: the word is presented combinationally on the
// accepting cycle so the consumer can register it without an extra stage.
module loader_byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0] idx;
   logic [23:0]      lo;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         idx <= '0;
         lo  <= '0;
      end else if (byte_en) begin
         idx <= idx + IDX_W'(1);
         case (idx)
            2'd0:    lo[7:0]   <= byte_in;
            2'd1:    lo[15:8]  <= byte_in;
            2'd2:    lo[23:16] <= byte_in;
            default: ;
         endcase
      end
   end

   assign word      = {byte_in, lo};
   assign word_done = byte_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// program_loader: loads an instruction image from a byte stream into IMEM.
// Stream: 4-byte LE word count N, N LE words, one 8-bit additive checksum.
//   clk, rst            - clock, synchronous active-low reset
//   in_valid/in_data    - byte stream input; in_ready accepts it
//   load_start          - restart a load from DONE or ERROR
//   imem_we/addr/wdata  - one registered write per completed word
//   cpu_hold            - CPU held in reset unless load is DONE
//   done / error        - load succeeded / failed
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  load_start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   // Largest legal word count is the full memory, 2^ADDR_WIDTH.
   localparam logic [32:0] CAP = 33'(1) << ADDR_WIDTH;

   state_t              state, state_nx;
   logic                accept, pk_en, pk_done, restart, last_word;
   logic [31:0]         pk_word;
   logic [CSUM_W-1:0]   csum;
   logic [ADDR_WIDTH:0] n_words, word_cnt;

   // Outputs decode from state only, so in_data never reaches an output.
   assign in_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
   assign done     = (state == ST_DONE);
   assign error    = (state == ST_ERROR);
   assign cpu_hold = (state != ST_DONE);

   assign accept    = in_valid && in_ready;
   assign pk_en     = accept && ((state == ST_LEN) || (state == ST_DATA));
   assign restart   = load_start && ((state == ST_DONE) || (state == ST_ERROR));
   assign last_word = (word_cnt + (ADDR_WIDTH+1)'(1)) == n_words;

   // Header and data share the packer; its lane index is the byte counter.
   loader_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (restart),
      .byte_en   (pk_en),
      .byte_in   (in_data),
      .word      (pk_word),
      .word_done (pk_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_LEN;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_LEN: begin
            if (pk_done) begin
               if ({1'b0, pk_word} > CAP) state_nx = ST_ERROR;
               else if (pk_word == 32'd0) state_nx = ST_CSUM;
               else                       state_nx = ST_DATA;
            end
         end
         ST_DATA:  if (pk_done && last_word) state_nx = ST_CSUM;
         ST_CSUM:  if (accept) state_nx = (in_data == csum) ? ST_DONE : ST_ERROR;
         ST_DONE,
         ST_ERROR: if (load_start) state_nx = ST_LEN;
         default:  state_nx = ST_LEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         csum       <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
      end else begin
         imem_we <= 1'b0;
         if (restart) begin
            imem_addr <= '0;
            csum      <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
         end else begin
            if (pk_en) csum <= csum + in_data;
            // Only consumed when N fits, so truncation of oversized N is harmless.
            if (state == ST_LEN && pk_done) n_words <= pk_word[ADDR_WIDTH:0];
            if (state == ST_DATA && pk_done) begin
               imem_we    <= 1'b1;
               imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
               imem_wdata <= pk_word;
               word_cnt   <= word_cnt + (ADDR_WIDTH+1)'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed tests for program_loader. A second instance
// with ADDR_WIDTH=4 exercises the word-count overflow limit.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_valid4;
   logic [7:0]  in_data, in_data4;
   logic        load_start, load_start4;
   logic        in_ready, in_ready4;
   logic        imem_we, imem_we4;
   logic [11:0] imem_addr;
   logic [3:0]  imem_addr4;
   logic [31:0] imem_wdata, imem_wdata4;
   logic        cpu_hold, cpu_hold4, done, done4, error, error4;

   int checks   = 0;
   int failures = 0;

   logic [11:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wr4_cnt;

   always #5 clk = ~clk;

   program_loader u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .load_start(load_start), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   program_loader #(.ADDR_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
      .in_ready(in_ready4), .load_start(load_start4), .imem_we(imem_we4),
      .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .cpu_hold(cpu_hold4),
      .done(done4), .error(error4)
   );

   // Record every IMEM write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
      end
      if (imem_we4 === 1'b1) wr4_cnt++;
   end

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int gap;
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) begin
         @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
      end
      @(negedge clk); in_valid = 1'b1; in_data = b;
      @(posedge clk); #1; in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] t;
         t = w >> (8 * i);
         send_byte(t[7:0], rnd);
      end
   endtask

   task automatic send_byte4(input logic [7:0] b);
      @(negedge clk); in_valid4 = 1'b1; in_data4 = b;
      @(posedge clk); #1; in_valid4 = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); load_start = 1'b1;
      @(posedge clk); #1; load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      settle();
      checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b expected 0", imem_we); end
      checks++; if (imem_addr !== 12'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
      checks++; if (imem_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %0h expected 0", imem_wdata); end
      checks++; if ({cpu_hold, done, error, in_ready} !== 4'b1001) begin failures++; $display("FAIL reset_flags: got hold/done/err/rdy=%b expected 1001", {cpu_hold, done, error, in_ready}); end
   endtask

   // N=2, words 0x00000013 and 0xDEADBEEF; checksum 0x4D.
   task automatic test_two_words();
      wa_q.delete(); wd_q.delete();
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      settle();
      checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL two_hold_before_csum: got %0b expected 1", cpu_hold); end
      send_byte(8'h4D, 1'b0);
      settle();
      checks++; if (wa_q.size() !== 2) begin failures++; $display("FAIL two_wr_count: got %0d expected 2", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 12'd0 || wd_q[0] !== 32'h0000_0013) begin failures++; $display("FAIL two_wr0: got %0h=%h expected 0=00000013", wa_q[0], wd_q[0]); end
         checks++; if (wa_q[1] !== 12'd1 || wd_q[1] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL two_wr1: got %0h=%h expected 1=deadbeef", wa_q[1], wd_q[1]); end
      end
      checks++; if ({done, cpu_hold, error, in_ready} !== 4'b1000) begin failures++; $display("FAIL two_done: got done/hold/err/rdy=%b expected 1000", {done, cpu_hold, error, in_ready}); end
      settle(); settle();
      checks++; if (imem_we !== 1'b0 || imem_addr !== 12'd1 || imem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL two_hold_vals: got we=%0b %0h=%h expected 0 1=deadbeef", imem_we, imem_addr, imem_wdata); end
   endtask

   // Restart from DONE, then N=0 with trailer 0x00.
   task automatic test_empty_image();
      pulse_start();
      settle();
      checks++; if ({cpu_hold, done, in_ready} !== 3'b101) begin failures++; $display("FAIL restart_flags: got hold/done/rdy=%b expected 101", {cpu_hold, done, in_ready}); end
      checks++; if (imem_addr !== 12'd0) begin failures++; $display("FAIL restart_addr: got %0h expected 0", imem_addr); end
      wa_q.delete(); wd_q.delete();
      send_word(32'd0, 1'b0);
      send_byte(8'h00, 1'b0);
      settle();
      checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL empty_wr_count: got %0d expected 0", wa_q.size()); end
      checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL empty_done: got done=%0b err=%0b expected 1 0", done, error); end
   endtask

   // N=1, word 0x12345678, checksum 0x15 sent as 0x16.
   task automatic test_bad_checksum();
      pulse_start();
      wa_q.delete(); wd_q.delete();
      send_word(32'd1, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      send_byte(8'h16, 1'b0);
      settle();
      checks++; if (wa_q.size() !== 1) begin failures++; $display("FAIL bad_wr_count: got %0d expected 1", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 12'd0 || wd_q[0] !== 32'h1234_5678) begin failures++; $display("FAIL bad_wr0: got %0h=%h expected 0=12345678", wa_q[0], wd_q[0]); end
      end
      checks++; if ({error, cpu_hold, in_ready, done} !== 4'b1100) begin failures++; $display("FAIL bad_flags: got err/hold/rdy/done=%b expected 1100", {error, cpu_hold, in_ready, done}); end
   endtask

   // Reset after 2 data bytes, then N=1 word 0xCAFEF00D, checksum 0xC6.
   task automatic test_mid_reset();
      pulse_start();
      wa_q.delete(); wd_q.delete();
      send_word(32'd1, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      settle();
      checks++; if (imem_we !== 1'b0 || imem_addr !== 12'd0 || imem_wdata !== 32'd0) begin failures++; $display("FAIL mrst_regs: got we=%0b %0h=%h expected 0 0=0", imem_we, imem_addr, imem_wdata); end
      checks++; if ({cpu_hold, error, done, in_ready} !== 4'b1001) begin failures++; $display("FAIL mrst_flags: got hold/err/done/rdy=%b expected 1001", {cpu_hold, error, done, in_ready}); end
      send_word(32'd1, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      send_byte(8'hC6, 1'b0);
      settle();
      checks++; if (wa_q.size() !== 1) begin failures++; $display("FAIL mrst_wr_count: got %0d expected 1", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 12'd0 || wd_q[0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL mrst_wr0: got %0h=%h expected 0=cafef00d", wa_q[0], wd_q[0]); end
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL mrst_done: got %0b expected 1", done); end
   endtask

   // From DONE: N=3 with random gaps and a stray load_start mid-image; checksum 0x50.
   task automatic test_back_to_back();
      pulse_start();
      wa_q.delete(); wd_q.delete();
      send_word(32'd3, 1'b1);
      send_word(32'h1111_1111, 1'b1);
      pulse_start();
      send_word(32'h2222_2222, 1'b1);
      send_word(32'h8000_0001, 1'b1);
      settle();
      checks++; if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_hold_pre: got hold=%0b rdy=%0b expected 1 1", cpu_hold, in_ready); end
      send_byte(8'h50, 1'b1);
      settle();
      checks++; if (wa_q.size() !== 3) begin failures++; $display("FAIL b2b_wr_count: got %0d expected 3", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 12'd0 || wd_q[0] !== 32'h1111_1111) begin failures++; $display("FAIL b2b_wr0: got %0h=%h expected 0=11111111", wa_q[0], wd_q[0]); end
         checks++; if (wa_q[1] !== 12'd1 || wd_q[1] !== 32'h2222_2222) begin failures++; $display("FAIL b2b_wr1: got %0h=%h expected 1=22222222", wa_q[1], wd_q[1]); end
         checks++; if (wa_q[2] !== 12'd2 || wd_q[2] !== 32'h8000_0001) begin failures++; $display("FAIL b2b_wr2: got %0h=%h expected 2=80000001", wa_q[2], wd_q[2]); end
      end
      checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL b2b_done: got done=%0b hold=%0b expected 1 0", done, cpu_hold); end
   endtask

   // ADDR_WIDTH=4: N=17 overflows, N=16 is the largest legal count.
   task automatic test_overflow();
      wr4_cnt = 0;
      send_byte4(8'h11); send_byte4(8'h00); send_byte4(8'h00);
      settle();
      checks++; if (error4 !== 1'b0) begin failures++; $display("FAIL ovf_early: got %0b expected 0", error4); end
      send_byte4(8'h00);
      settle();
      checks++; if (error4 !== 1'b1 || in_ready4 !== 1'b0 || cpu_hold4 !== 1'b1) begin failures++; $display("FAIL ovf_error: got err=%0b rdy=%0b hold=%0b expected 1 0 1", error4, in_ready4, cpu_hold4); end
      checks++; if (wr4_cnt !== 0) begin failures++; $display("FAIL ovf_writes: got %0d expected 0", wr4_cnt); end
      @(negedge clk); load_start4 = 1'b1;
      @(posedge clk); #1; load_start4 = 1'b0;
      send_byte4(8'h10); send_byte4(8'h00); send_byte4(8'h00); send_byte4(8'h00);
      settle();
      checks++; if (error4 !== 1'b0 || in_ready4 !== 1'b1) begin failures++; $display("FAIL cap_ok: got err=%0b rdy=%0b expected 0 1", error4, in_ready4); end
   endtask

   initial begin
      in_valid = 1'b0; in_data = 8'h00; load_start = 1'b0;
      in_valid4 = 1'b0; in_data4 = 8'h00; load_start4 = 1'b0;
      wr4_cnt = 0;
      test_reset();
      test_two_words();
      test_empty_image();
      test_bad_checksum();
      test_mid_reset();
      test_back_to_back();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the instruction-memory word-address width (capacity 2^ADDR_WIDTH words).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-004 in_valid  input  1  byte on in_data is offered this cycle.
REQ-005 in_data  input  8  received byte (UART RX stream).
REQ-006 in_ready  output  1  loader accepts the byte; transfer occurs when in_valid && in_ready.
REQ-007 load_start  input  1  single-cycle request to begin a new load from DONE or ERROR.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_WIDTH  word address of the write.
REQ-010 imem_wdata  output  32  word to write.
REQ-011 cpu_hold  output  1  holds the CPU in reset while 1.
REQ-012 done  output  1  image loaded and checksum matched.
REQ-013 error  output  1  load failed (length overflow or checksum mismatch).

Function
REQ-014 Stream format SHALL be: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian, then one checksum byte.
REQ-015 States SHALL be LEN, DATA, CSUM, DONE, ERROR; reset enters LEN.
REQ-016 in_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in DONE and ERROR.
REQ-017 LEN: after the 4th header byte is accepted, the FSM SHALL go to ERROR if N > 2^ADDR_WIDTH, to CSUM if N == 0, and to DATA otherwise.
REQ-018 DATA: every 4th accepted byte SHALL complete a word; on the following cycle imem_we=1 and imem_wdata holds the word, with byte 0 in bits [7:0].
REQ-019 imem_addr SHALL be 0 for the first word and increment by 1 after each write; imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-020 After the Nth word completes, the FSM SHALL go to CSUM; the write of word N SHALL still be issued on the next cycle.
REQ-021 The running checksum SHALL be the 8-bit sum, mod 256, of all header and data bytes.
REQ-022 CSUM: on the accepted trailer byte, the FSM SHALL go to DONE if the byte equals the running sum, otherwise to ERROR.
REQ-023 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR; cpu_hold SHALL be 0 only in DONE.
REQ-024 load_start SHALL be ignored in LEN, DATA and CSUM.
REQ-025 load_start in DONE or ERROR SHALL clear the byte counter, word counter, address and checksum and enter LEN; cpu_hold SHALL return to 1 on the same edge.
REQ-026 Gaps of any length between valid bytes SHALL not affect the result; bytes are counted only on transfer.
REQ-027 Partial words or headers SHALL be retained across idle cycles, with no timeout.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set: state=LEN, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, and all counters and the checksum to 0.
REQ-029 Reset mid-load SHALL discard any partial header, word or checksum.
REQ-030 No imem_we pulse SHALL be issued in the cycle after a reset edge.

Structure
REQ-031 Package loader_pkg SHALL hold the state enum, HDR_BYTES=4, BYTES_PER_WORD=4 and the checksum width.
REQ-032 One sub-module, loader_byte_packer, SHALL assemble 4 bytes into a little-endian word and flag completion; the FSM and counters stay in program_loader.
REQ-033 The design SHALL contain no latches and no combinational path from in_data to any output.

Verification
REQ-034 N=2, words 0x00000013 and 0xDEADBEEF, correct checksum -> two writes: addr 0 = 0x00000013 and addr 1 = 0xDEADBEEF; then done=1 and cpu_hold=0.
REQ-035 N=0 followed by trailer 0x00 -> no imem_we pulse; done=1.
REQ-036 N=1 with the trailer off by 1 -> one write, then error=1, cpu_hold=1 and in_ready=0.
REQ-037 ADDR_WIDTH=4 with N=17 -> ERROR immediately after the 4th header byte; no writes.
REQ-038 rst=0 after 2 data bytes, followed by a full valid N=1 stream -> the single write lands at addr 0 with the new data; done=1.
REQ-039 From DONE, pulse load_start with in_valid toggling randomly and a second image N=3 -> writes at addr 0..2; cpu_hold=1 until the checksum is accepted.
